refresh_scheduler: RTL

//   Consumer side of the refresh-interval counter. Counts refresh_flag pulses as

---
 rtl/refresh_scheduler_if.sv | 22 ++
 rtl/refresh_scheduler.sv | 110 +++++++++++
 2 files changed

// File: rtl/refresh_scheduler_if.sv
// Command-bus handshake between the refresh scheduler (master) and the main
// DRAM controller / command mux (slave).
interface refresh_scheduler_if;
  logic ctrl_idle;
  logic ref_ack;
  logic ref_req;
  logic ref_active;
  logic cmd_valid;
  logic cmd_pre_all;
  logic cmd_ref;
  logic cmd_ready;

  modport master (
    input  ctrl_idle, ref_ack, cmd_ready,
    output ref_req, ref_active, cmd_valid, cmd_pre_all, cmd_ref
  );

  modport slave (
    output ctrl_idle, ref_ack, cmd_ready,
    input  ref_req, ref_active, cmd_valid, cmd_pre_all, cmd_ref
  );
endinterface

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: counts owed refreshes, wins the command bus, then issues
// PRECHARGE-ALL / tRP / REFRESH / tRFC, bursting while refreshes remain owed.
module refresh_scheduler #(
  parameter int MAX_PENDING = 8,
  parameter int TRP         = 3,
  parameter int TRFC        = 44,
  parameter int CNT_W       = 8,
  localparam int PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                refresh_flag,
  refresh_scheduler_if.master bus,
  output logic [PW-1:0]       pending_cnt,
  output logic                overflow
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PRE,
    PRE_WAIT,
    REF,
    RFC_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(TRP - 1);
  localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'(TRFC - 1);
  localparam logic [PW-1:0]    PEND_MAX  = PW'(MAX_PENDING);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             ref_accept;

  assign ref_accept = (state_q == REF) && bus.cmd_ready;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:     if (pending_q != '0) state_d = REQ;
      REQ:      if (bus.ref_ack && bus.ctrl_idle) state_d = PRE;
      PRE: begin
        if (bus.cmd_ready) begin
          state_d = PRE_WAIT;
          timer_d = TRP_LOAD;
        end
      end
      PRE_WAIT: begin
        if (timer_q == '0) state_d = REF;
        else               timer_d = timer_q - 1'b1;
      end
      REF: begin
        if (bus.cmd_ready) begin
          state_d = RFC_WAIT;
          timer_d = TRFC_LOAD;
        end
      end
      RFC_WAIT: begin
        // Owed refreshes left: keep the bus and go straight to the next PRECHARGE.
        if (timer_q == '0) state_d = (pending_q != '0) ? PRE : IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default:  state_d = IDLE;
    endcase
  end

  // A flag and a REF accept in the same cycle cancel; a lone flag at
  // saturation is lost and flagged as overflow.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (refresh_flag && !ref_accept) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + PW'(1);
    end else if (!refresh_flag && ref_accept) begin
      pending_d = pending_q - PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ref_req     = (state_q != IDLE);
  assign bus.ref_active  = (state_q == PRE) || (state_q == PRE_WAIT) ||
                           (state_q == REF) || (state_q == RFC_WAIT);
  assign bus.cmd_valid   = (state_q == PRE) || (state_q == REF);
  assign bus.cmd_pre_all = (state_q == PRE);
  assign bus.cmd_ref     = (state_q == REF);
  assign pending_cnt     = pending_q;
  assign overflow        = overflow_q;

endmodule
